// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    localparam int INSTR_W  = 32;
    localparam int PC_STEP  = 4;
    // Entry pc field is sized for the widest supported XLEN; narrower PCs are zero-extended.
    localparam int PC_W_MAX = 64;

    typedef struct packed {
        logic [PC_W_MAX-1:0] pc;
        logic [INSTR_W-1:0]  instr;
        logic                filled;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order prefetch queue: entries are allocated at request time and filled
// later by memory responses, so head/fill/tail advance independently.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    localparam int CW   = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               i_flush,
    input  logic               i_alloc,
    input  logic [XLEN-1:0]    i_alloc_pc,
    input  logic               i_fill,
    input  logic [INSTR_W-1:0] i_fill_instr,
    input  logic               i_pop,
    output logic [CW-1:0]      o_count,
    output logic [CW-1:0]      o_unfilled,
    output fetch_entry_t       o_head
);

    localparam int PW = $clog2(DEPTH);

    fetch_entry_t  r_mem [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_fill;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_unfilled;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset || i_flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i].filled <= 1'b0;
            end
            r_head     <= '0;
            r_fill     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_unfilled <= '0;
        end else begin
            if (i_alloc) begin
                r_mem[r_tail].pc     <= PC_W_MAX'(i_alloc_pc);
                r_mem[r_tail].filled <= 1'b0;
                r_tail               <= r_tail + 1'b1;
            end
            if (i_fill) begin
                r_mem[r_fill].instr  <= i_fill_instr;
                r_mem[r_fill].filled <= 1'b1;
                r_fill               <= r_fill + 1'b1;
            end
            if (i_pop) begin
                r_mem[r_head].filled <= 1'b0;
                r_head               <= r_head + 1'b1;
            end
            r_count    <= r_count + CW'(i_alloc) - CW'(i_pop);
            r_unfilled <= r_unfilled + CW'(i_alloc) - CW'(i_fill);
        end
    end

    assign o_count    = r_count;
    assign o_unfilled = r_unfilled;
    assign o_head     = r_mem[r_head];

endmodule

// File: rtl/fetch_unit_pq.sv
// Fetch engine: owns the fetch PC and the count of stale in-flight responses,
// and sequences requests, fills, pops and redirect flushes around fetch_queue.
module fetch_unit_pq
    import fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic               clk,
    input  logic               reset,
    output logic               imem_req_valid,
    input  logic               imem_req_ready,
    output logic [XLEN-1:0]    imem_req_addr,
    input  logic               imem_rsp_valid,
    input  logic [INSTR_W-1:0] imem_rsp_data,
    input  logic               redirect_valid,
    input  logic [XLEN-1:0]    redirect_pc,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr_data,
    output logic [XLEN-1:0]    instr_pc,
    output logic [XLEN-1:0]    instr_pc_plus4
);

    localparam int CW = $clog2(DEPTH + 1);

    logic [XLEN-1:0] r_fpc;
    logic [CW-1:0]   r_drop_cnt;

    logic            w_req_valid;
    logic            w_req_fire;
    logic            w_fill;
    logic            w_instr_valid;
    logic            w_pop;
    logic [CW-1:0]   w_count;
    logic [CW-1:0]   w_unfilled;
    logic [CW-1:0]   w_drop_sum;
    logic [CW-1:0]   w_drop_redir;
    fetch_entry_t    w_head;

    assign w_req_valid   = !reset && (w_count < CW'(DEPTH)) && !redirect_valid;
    assign w_req_fire    = w_req_valid && imem_req_ready;
    assign w_fill        = imem_rsp_valid && (r_drop_cnt == '0) && (w_unfilled != '0)
                           && !redirect_valid;
    assign w_instr_valid = !reset && w_head.filled && !redirect_valid;
    assign w_pop         = w_instr_valid && instr_ready;

    // Every unfilled entry becomes a stale response on redirect; a response
    // arriving in the same cycle retires one of them (or one already stale).
    assign w_drop_sum    = r_drop_cnt + w_unfilled;
    assign w_drop_redir  = w_drop_sum - CW'(imem_rsp_valid && (w_drop_sum != '0));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fpc      <= RESET_PC;
            r_drop_cnt <= '0;
        end else if (redirect_valid) begin
            r_fpc      <= {redirect_pc[XLEN-1:2], 2'b00};
            r_drop_cnt <= w_drop_redir;
        end else begin
            if (w_req_fire) begin
                r_fpc <= r_fpc + XLEN'(PC_STEP);
            end
            if (imem_rsp_valid && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - 1'b1;
            end
        end
    end

    fetch_queue #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH)
    ) u_queue (
        .clk          (clk),
        .reset        (reset),
        .i_flush      (redirect_valid),
        .i_alloc      (w_req_fire),
        .i_alloc_pc   (r_fpc),
        .i_fill       (w_fill),
        .i_fill_instr (imem_rsp_data),
        .i_pop        (w_pop),
        .o_count      (w_count),
        .o_unfilled   (w_unfilled),
        .o_head       (w_head)
    );

    assign imem_req_valid = w_req_valid;
    assign imem_req_addr  = r_fpc;
    assign instr_valid    = w_instr_valid;
    assign instr_data     = w_head.instr;
    assign instr_pc       = XLEN'(w_head.pc);
    assign instr_pc_plus4 = instr_pc + XLEN'(PC_STEP);

endmodule

// File: tb/tb_fetch_unit_pq.sv
// Scoreboard bench for fetch_unit_pq: in-order memory model, expected PC stream
// pushed by the stimulus side, delivered instructions checked by a monitor.
module tb_fetch_unit_pq;

    localparam int          XLEN     = 32;
    localparam int          DEPTH    = 4;
    localparam logic [31:0] RESET_PC = 32'h0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = 32'h0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr_data;
    logic [31:0] instr_pc;
    logic [31:0] instr_pc_plus4;

    fetch_unit_pq #(.XLEN(XLEN), .DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
        .clk            (clk),
        .reset          (reset),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .instr_valid    (instr_valid),
        .instr_ready    (instr_ready),
        .instr_data     (instr_data),
        .instr_pc       (instr_pc),
        .instr_pc_plus4 (instr_pc_plus4)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int base = 0;
    int n_deliv = 0;
    int first_deliv = -1;
    int n_req = 0;
    int mem_lat = 1;
    bit mem_rand_lat = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] mdata(input logic [31:0] a);
        return a ^ 32'hDEAD_BEEF;
    endfunction

    // Memory: in order, at most one response per cycle, each no earlier than its due cycle.
    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t pend[$];
    mreq_t m;

    always @(negedge clk) begin
        imem_rsp_valid = 1'b0;
        if (reset) begin
            pend.delete();
        end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mdata(pend[0].addr);
            void'(pend.pop_front());
        end
        #2;
        if (!reset && imem_req_valid && imem_req_ready) begin
            m.addr = imem_req_addr;
            m.due  = cyc + (mem_rand_lat ? int'($urandom_range(1, 4)) : mem_lat);
            pend.push_back(m);
            n_req++;
        end
    end

    logic [31:0] exp_q[$];
    logic [31:0] exp_next = RESET_PC;
    logic [31:0] exp_v;

    always @(negedge clk) begin
        #2;
        if (!reset && imem_rsp_valid && dut.w_count == 0 && dut.r_drop_cnt == 0) begin
            errors++;
            $display("FAIL protocol: response with empty queue and no pending drops at cycle %0d", cyc);
        end
        if (!reset && instr_valid && instr_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL deliver: got pc %h, expected no delivery", instr_pc);
            end else begin
                exp_v = exp_q.pop_front();
                if (instr_pc !== exp_v || instr_data !== mdata(exp_v) ||
                    instr_pc_plus4 !== exp_v + 32'd4) begin
                    errors++;
                    $display("FAIL deliver: got pc %h data %h pc4 %h, expected pc %h data %h pc4 %h",
                             instr_pc, instr_data, instr_pc_plus4, exp_v, mdata(exp_v), exp_v + 32'd4);
                end
            end
            if (first_deliv < 0) first_deliv = cyc;
            n_deliv++;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        if (!reset) begin
            while (exp_q.size() < 8) begin
                exp_q.push_back(exp_next);
                exp_next = exp_next + 32'd4;
            end
        end
    endtask

    task automatic do_redirect(input logic [31:0] tgt);
        redirect_valid = 1'b1;
        redirect_pc    = tgt;
        exp_q.delete();
        exp_next = {tgt[31:2], 2'b00};
    endtask

    // Returns at cycle c0: the first cycle with reset low.
    task automatic do_reset();
        tick();
        reset = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b0;
        imem_req_ready = 1'b0; mem_rand_lat = 1'b0;
        #1;
        chk("rst_req_valid", imem_req_valid, 0);
        chk("rst_instr_valid", instr_valid, 0);
        tick();
        #1;
        chk("rst_drop_cnt", dut.r_drop_cnt, 0);
        chk("rst_count", dut.w_count, 0);
        exp_q.delete();
        exp_next = RESET_PC;
        n_deliv = 0; first_deliv = -1; n_req = 0;
        tick();
        reset = 1'b0;
        base = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        // Free run, 1-cycle memory
        do_reset();
        mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        #1;
        chk("first_req_valid", imem_req_valid, 1);
        chk("first_req_addr", imem_req_addr, RESET_PC);
        repeat (12) tick();
        #1;
        chk("free_first_cycle", first_deliv - base, 2);
        chk("free_throughput", n_deliv, 10);

        // Decode stall (mid-operation reset precedes it)
        do_reset();
        mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b0;
        repeat (9) tick();
        #3;
        chk("stall_req_count", n_req, 4);
        chk("stall_req_valid", imem_req_valid, 0);
        tick();
        instr_ready = 1'b1;
        tick();
        #1;
        chk("stall_resume_valid", imem_req_valid, 1);
        chk("stall_resume_addr", imem_req_addr, 32'h10);
        repeat (10) tick();
        #1;
        chk("stall_deliv_count", n_deliv, 11);

        // Redirect with two requests in flight, 3-cycle memory
        do_reset();
        mem_lat = 3; imem_req_ready = 1'b1; instr_ready = 1'b1;
        tick();
        tick();
        imem_req_ready = 1'b0;
        do_redirect(32'h100);
        #1;
        chk("redir_req_blocked", imem_req_valid, 0);
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1;
        #1;
        chk("redir_drop2", dut.r_drop_cnt, 2);
        chk("redir_req_addr", imem_req_addr, 32'h100);
        tick();
        #1;
        chk("redir_drop1", dut.r_drop_cnt, 1);
        tick();
        #1;
        chk("redir_drop0", dut.r_drop_cnt, 0);
        repeat (6) tick();
        #1;
        chk("redir_first_cycle", first_deliv - base, 7);
        chk("redir_deliv_count", n_deliv, 4);

        // Redirect coincident with the response for 0x8
        do_reset();
        mem_lat = 2; imem_req_ready = 1'b1; instr_ready = 1'b0;
        repeat (4) tick();
        do_redirect(32'h200);
        instr_ready = 1'b1;
        #1;
        chk("coin_req_count", n_req, 4);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("coin_drop1", dut.r_drop_cnt, 1);
        chk("coin_req_addr", imem_req_addr, 32'h200);
        tick();
        #1;
        chk("coin_drop0", dut.r_drop_cnt, 0);
        repeat (4) tick();
        #1;
        chk("coin_first_cycle", first_deliv - base, 8);
        chk("coin_deliv_count", n_deliv, 2);

        // Misaligned redirect and address wrap
        do_reset();
        mem_lat = 1; imem_req_ready = 1'b1; instr_ready = 1'b1;
        tick();
        tick();
        do_redirect(32'hFFFF_FFFF);
        tick();
        redirect_valid = 1'b0;
        #1;
        chk("wrap_addr_hi", imem_req_addr, 32'hFFFF_FFFC);
        tick();
        #1;
        chk("wrap_addr_zero", imem_req_addr, 32'h0);
        repeat (6) tick();
        #1;
        chk("wrap_deliv_count", n_deliv, 5);

        // Random handshakes, latencies and redirects
        do_reset();
        mem_rand_lat = 1'b1;
        repeat (10000) begin
            tick();
            redirect_valid = 1'b0;
            imem_req_ready = ($urandom_range(0, 3) != 0);
            instr_ready    = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 39) == 0) do_redirect($urandom);
        end
        tick();
        redirect_valid = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
        repeat (20) tick();
        #1;
        chk("rand_progress", 32'(n_deliv > 2000), 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit_pq.md
# fetch_unit_pq

Parametrised instruction-fetch front end for the 5-stage RV32I pipeline. It replaces the bare PC register, PC+4 adder and PC mux with a latency-tolerant fetch engine: a valid/ready request port to instruction memory, an in-order prefetch queue of `DEPTH` entries, a decode-side valid/ready handshake that carries stalls, and redirect handling that flushes the queue and discards in-flight responses. The IF/ID register consumes its output.

## Interface
- `XLEN`, 32: address/PC width.
- `DEPTH`, 4: prefetch queue entries; power of two, ≥2. Full throughput needs ≥3.
- `RESET_PC`, 0: PC fetched first after reset; bits [1:0] must be 0.
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: synchronous, active-high.
- `imem_req_valid` output 1: fetch request.
- `imem_req_ready` input 1: memory accepts the request.
- `imem_req_addr` output XLEN: word-aligned fetch address.
- `imem_rsp_valid` input 1: instruction returned, in request order, no earlier than the cycle after acceptance.
- `imem_rsp_data` input 32: returned instruction.
- `redirect_valid` input 1: taken branch or jump from Execute (PCSrcE).
- `redirect_pc` input XLEN: target (PCTargetE); bits [1:0] are ignored and treated as 00.
- `instr_valid` output 1: head instruction available.
- `instr_ready` input 1: decode accepts; low means stall.
- `instr_data` output 32, `instr_pc` output XLEN, `instr_pc_plus4` output XLEN: head instruction, its PC, and PC+4.

## Operation
- State:
  - fetch PC `fpc`;
  - circular queue of entries {pc, instr, filled} with head, fill and tail pointers;
  - `count` = allocated entries;
  - `drop_cnt` = in-flight responses to discard.
- Request: `imem_req_valid = !reset && count < DEPTH && !redirect_valid`. `imem_req_addr = fpc`.
- On a request handshake:
  - allocate an entry at the tail with pc=`fpc`, filled=0;
  - `fpc += 4`, wrapping modulo 2^XLEN.
- Response, `drop_cnt > 0`: discard the data and decrement `drop_cnt`.
- Response, `drop_cnt == 0`: write `instr` into the entry at the fill pointer, set filled, advance the fill pointer.
- A response arriving while `count == 0` and `drop_cnt == 0` is ignored. It is a protocol error; the bench asserts that it never occurs.
- Output:
  - `instr_valid = head.filled && !redirect_valid`;
  - the head entry fields drive `instr_*`;
  - on `instr_valid && instr_ready`, pop the head.
- Redirect (`redirect_valid` = 1):
  - all entries are invalidated; count, head, fill and tail pointers reset to 0;
  - `fpc` ← `{redirect_pc[XLEN-1:2], 2'b00}`;
  - `drop_cnt` ← `drop_cnt + unfilled − imem_rsp_valid`, where `unfilled` = allocated-but-unfilled entries;
  - no request or decode handshake occurs that cycle.
- Invariant: `drop_cnt + unfilled` = outstanding memory requests ≤ DEPTH. `drop_cnt` width is clog2(DEPTH+1).
- Back-to-back redirects accumulate into `drop_cnt` correctly.
- Full queue (`count == DEPTH`): `imem_req_valid` = 0 until a pop. A pop and an allocation in the same cycle leave `count` unchanged.
- Empty queue, or head not filled: `instr_valid` = 0.

## Timing
- Reset values:
  - `fpc = RESET_PC`;
  - `count`, `drop_cnt` and all pointers = 0;
  - every filled flag = 0;
  - `imem_req_valid` = 0 and `instr_valid` = 0 while `reset` is high.
- First request: the cycle after `reset` falls, with `imem_req_addr = RESET_PC`.
- Latency: request accepted at cycle n, response at cycle m ≥ n+1, `instr_valid` at m+1. No combinational path from `imem_rsp_*` to `instr_*`.
- With 1-cycle memory, `imem_req_ready` = 1 and `instr_ready` = 1, steady state is one instruction per cycle.
- Redirect at cycle r: a request to `redirect_pc` is issued at r+1, and its instruction is valid no earlier than r+3.
- Reset asserted mid-operation:
  - all state clears in that cycle, including `drop_cnt`;
  - the memory is reset by the same signal, so no pre-reset responses follow.
- `imem_req_valid` and `instr_valid` are combinational functions of registered state and `redirect_valid` only.

## Structure
- Package `fetch_pkg`:
  - `fetch_entry_t` struct (pc, instr, filled);
  - `INSTR_W = 32`;
  - `PC_STEP = 4`.
- Sub-module `fetch_queue`: parametrised circular buffer with allocate, fill and pop ports plus a flush input; it reports `count`, `unfilled` and head entry.
- The top holds `fpc`, `drop_cnt` and the handshake logic.

## Test plan
- Reset then free run: 1-cycle memory, `instr_ready` = 1 → PCs 0x0, 0x4, 0x8, … delivered one per cycle from cycle 3; `instr_pc_plus4` = pc+4.
- Decode stall: `instr_ready` held low 10 cycles (DEPTH=4) → exactly 4 requests issued, then `imem_req_valid` = 0; on release, PCs 0x0–0xC delivered in order, then fetch resumes at 0x10.
- Redirect with 2 in flight: 3-cycle memory, redirect to 0x100 while 2 requests are outstanding → `drop_cnt` = 2; both stale responses are discarded; first delivered PC is 0x100.
- Redirect coincident with a response: redirect to 0x200 on the same cycle a response for 0x8 arrives, with 1 further request outstanding → `drop_cnt` = 1; 0x8 is never delivered; 0x200 follows.
- Misaligned redirect and wrap: `redirect_pc` = 0xFFFF_FFFF → fetch at 0xFFFF_FFFC, then at 0x0000_0000.
- Random `imem_req_ready`, memory latency 1–4, `instr_ready` and redirects over 10k cycles, checked against a reference PC model → the delivered PC stream matches, with no ordering error or dropped instruction.
